// File: rtl/fsm_ctrl_pkg.sv
// Shared state encoding for the multi-channel job controller and its bench.
// Pure definitions, no logic.
package fsm_ctrl_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_WORK  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;
endpackage

// File: rtl/fsm_controller_mc_rr_arbiter.sv
// Round-robin pick: first requester after ptr, wrapping; combinational, 0-cycle latency.
// No backpressure: vld simply drops when no channel requests.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx,
  output logic              vld
);

  always_comb begin
    int          c;
    logic [CH_W-1:0] w_c;
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    c   = 0;
    w_c = '0;
    // Scan ptr+1 .. ptr+NUM_CH so the last-served channel is checked last.
    for (int i = 1; i <= NUM_CH; i++) begin
      c   = (int'(ptr) + i) % NUM_CH;
      w_c = CH_W'(c);
      if (!vld && req[w_c]) begin
        vld      = 1'b1;
        gnt[w_c] = 1'b1;
        idx      = w_c;
      end
    end
  end

endmodule

// File: rtl/fsm_controller_mc.sv
// Shares one worker among NUM_CH requesters: grant 1 cycle after request, ack in DONE; min period 3 cycles.
// Requests are held off outside IDLE; FSM_CTRL_WATCHDOG_EN adds a WORK timeout that aborts via ERROR.
module fsm_controller_mc #(
  parameter int  NUM_CH      = 4,
  parameter int  CNT_W       = 8,
  parameter int  TIMEOUT_CYC = 16,
  localparam int CH_W        = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] start,
  input  logic              done,
  output logic              busy,
  output logic              ready,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   ch_id,
  output logic [NUM_CH-1:0] ack,
  output logic              err,
  output logic [CNT_W-1:0]  job_cnt
);
  import fsm_ctrl_pkg::*;

  state_e            r_state;
  state_e            w_next;
  logic [NUM_CH-1:0] r_grant;
  logic [CH_W-1:0]   r_ch_id;
  logic [CH_W-1:0]   r_ptr;
  logic [CNT_W-1:0]  r_job_cnt;
  logic [NUM_CH-1:0] w_arb_gnt;
  logic [CH_W-1:0]   w_arb_idx;
  logic              w_arb_vld;
  logic              w_wd_expired;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req (start),
    .ptr (r_ptr),
    .gnt (w_arb_gnt),
    .idx (w_arb_idx),
    .vld (w_arb_vld)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_arb_vld) w_next = ST_WORK;
      ST_WORK: begin
        // A done on the final allowed cycle beats the timeout.
        if (done)              w_next = ST_DONE;
        else if (w_wd_expired) w_next = ST_ERROR;
      end
      ST_DONE:  w_next = ST_IDLE;
      ST_ERROR: w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant   <= '0;
      r_ch_id   <= '0;
      r_ptr     <= CH_W'(NUM_CH - 1);
      r_job_cnt <= '0;
    end else begin
      if (r_state == ST_IDLE && w_arb_vld) begin
        r_grant <= w_arb_gnt;
        r_ch_id <= w_arb_idx;
      end else if (r_state == ST_WORK && w_next != ST_WORK) begin
        r_grant <= '0;
      end
      if (r_state == ST_DONE)                          r_job_cnt <= r_job_cnt + CNT_W'(1);
      if (r_state == ST_DONE || r_state == ST_ERROR)   r_ptr     <= r_ch_id;
    end
  end

`ifdef FSM_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] r_wd_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_wd_cnt <= '0;
    else if (r_state != ST_WORK) r_wd_cnt <= '0;
    else                         r_wd_cnt <= r_wd_cnt + WD_W'(1);
  end

  assign w_wd_expired = (r_state == ST_WORK) && (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign err          = (r_state == ST_ERROR);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYC > 0);
  assign w_wd_expired     = 1'b0;
  assign err              = 1'b0;
`endif

  assign busy    = (r_state == ST_WORK);
  assign ready   = (r_state == ST_IDLE);
  assign grant   = r_grant;
  assign ch_id   = r_ch_id;
  assign ack     = (r_state == ST_DONE) ? (NUM_CH'(1) << r_ch_id) : '0;
  assign job_cnt = r_job_cnt;

endmodule

// File: tb/tb_fsm_controller_mc.sv
// Randomized job traffic against a transaction-level model of the shared-worker controller.
module tb_fsm_controller_mc;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 8;
  localparam int TIMEOUT_CYC = 16;
  localparam int CH_W        = $clog2(NUM_CH);
`ifdef FSM_CTRL_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] start;
  logic              done;
  logic              busy, ready, err;
  logic [NUM_CH-1:0] grant, ack;
  logic [CH_W-1:0]   ch_id;
  logic [CNT_W-1:0]  job_cnt;

  int n_chk = 0;
  int n_err = 0;
  int m_last;
  int m_cnt;

  fsm_controller_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .done(done),
    .busy(busy), .ready(ready), .grant(grant), .ch_id(ch_id),
    .ack(ack), .err(err), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "simulation time limit");
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Winner = requesting channel at the smallest circular distance after the last served one.
  function automatic int pick(input logic [NUM_CH-1:0] req, input int last);
    int best, bestd, d;
    best  = -1;
    bestd = NUM_CH;
    for (int c = 0; c < NUM_CH; c++) begin
      if (req[c]) begin
        d = (c - last - 1 + 2 * NUM_CH) % NUM_CH;
        if (d < bestd) begin
          bestd = d;
          best  = c;
        end
      end
    end
    return best;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    start   = '0;
    done    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_eq("rst_busy",  32'(busy),    32'd0);
    chk_eq("rst_ready", 32'(ready),   32'd1);
    chk_eq("rst_grant", 32'(grant),   32'd0);
    chk_eq("rst_ch_id", 32'(ch_id),   32'd0);
    chk_eq("rst_ack",   32'(ack),     32'd0);
    chk_eq("rst_err",   32'(err),     32'd0);
    chk_eq("rst_cnt",   32'(job_cnt), 32'd0);
    reset_n = 1'b1;
    m_last  = NUM_CH - 1;
    m_cnt   = 0;
  endtask

  // One job from IDLE: done arrives on WORK cycle len unless hang.
  task automatic run_job(input logic [NUM_CH-1:0] req, input int len, input bit hang, output int got_ch);
    int w, n_work;
    bit exp_err;
    logic [NUM_CH-1:0] oh;
    w       = pick(req, m_last);
    oh      = NUM_CH'(1) << w;
    exp_err = WD_EN && (hang || len > TIMEOUT_CYC);
    n_work  = exp_err ? TIMEOUT_CYC : len;
    start   = req;
    done    = 1'b0;
    @(posedge clk); #1;
    got_ch = int'(ch_id);
    chk_eq("grant",   32'(grant), 32'(oh));
    chk_eq("ch_id",   32'(ch_id), 32'(w));
    chk_eq("busy",    32'(busy),  32'd1);
    chk_eq("ready_w", 32'(ready), 32'd0);
    for (int c = 1; c <= n_work; c++) begin
      start = NUM_CH'($urandom);
      done  = (c == len) && !hang;
      @(posedge clk); #1;
      if (c < n_work) begin
        chk_eq("work_busy",  32'(busy),  32'd1);
        chk_eq("work_grant", 32'(grant), 32'(oh));
        chk_eq("work_ack",   32'(ack),   32'd0);
      end
    end
    if (exp_err) begin
      chk_eq("err_pulse", 32'(err),  32'd1);
      chk_eq("err_ack",   32'(ack),  32'd0);
      chk_eq("err_busy",  32'(busy), 32'd0);
    end else begin
      chk_eq("ack",       32'(ack),   32'(oh));
      chk_eq("done_err",  32'(err),   32'd0);
      chk_eq("done_busy", 32'(busy),  32'd0);
      chk_eq("done_rdy",  32'(ready), 32'd0);
      chk_eq("done_gnt",  32'(grant), 32'd0);
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end
    m_last = w;
    start  = NUM_CH'($urandom);
    done   = 1'($urandom);
    @(posedge clk); #1;
    chk_eq("idle_ready", 32'(ready),   32'd1);
    chk_eq("idle_busy",  32'(busy),    32'd0);
    chk_eq("idle_ack",   32'(ack),     32'd0);
    chk_eq("idle_err",   32'(err),     32'd0);
    chk_eq("idle_ch",    32'(ch_id),   32'(w));
    chk_eq("job_cnt",    32'(job_cnt), 32'(m_cnt));
    start = '0;
    done  = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      start = '0;
      done  = 1'($urandom);
      @(posedge clk); #1;
      chk_eq("gap_ready", 32'(ready),   32'd1);
      chk_eq("gap_cnt",   32'(job_cnt), 32'(m_cnt));
    end
    done = 1'b0;
  endtask

  initial begin
    int ch;
    int rr_exp [5];
    rr_exp = '{0, 1, 2, 3, 0};

    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_job(4'b1111, 1, 1'b0, ch);
      chk_eq("rr_order", 32'(ch), 32'(rr_exp[i]));
    end

    do_reset();
    run_job(4'b0100, 5, 1'b0, ch);
    chk_eq("single_ch",  32'(ch),      32'd2);
    chk_eq("single_cnt", 32'(job_cnt), 32'd1);

    for (int i = 0; i < 60; i++) begin
      run_job(NUM_CH'($urandom_range(1, 15)), $urandom_range(1, 6), 1'b0, ch);
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end

`ifdef FSM_CTRL_WATCHDOG_EN
    run_job(4'b0001, 0, 1'b1, ch);
    run_job(4'b0011, 2, 1'b0, ch);
    chk_eq("wd_next_ch", 32'(ch), 32'd1);
    run_job(4'b0001, TIMEOUT_CYC, 1'b0, ch);
    run_job(4'b0110, TIMEOUT_CYC + 3, 1'b0, ch);
`else
    run_job(4'b0010, 40, 1'b0, ch);
`endif

    start = 4'b1000;
    done  = 1'b0;
    @(posedge clk); #1;
    chk_eq("pre_rst_busy", 32'(busy), 32'd1);
    start = '0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk_eq("mid_rst_busy",  32'(busy),    32'd0);
    chk_eq("mid_rst_grant", 32'(grant),   32'd0);
    chk_eq("mid_rst_ready", 32'(ready),   32'd1);
    chk_eq("mid_rst_cnt",   32'(job_cnt), 32'd0);
    chk_eq("mid_rst_ack",   32'(ack),     32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_last  = NUM_CH - 1;
    m_cnt   = 0;

    for (int i = 0; i < (1 << CNT_W); i++)
      run_job(NUM_CH'($urandom_range(1, 15)), $urandom_range(1, 3), 1'b0, ch);
    chk_eq("wrap_cnt", 32'(job_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
